// File: rtl/dwrr_pkg.sv
// rtl/dwrr_pkg.sv - shared types and helpers for the DWRR dispatcher
//
// Contents:
//   state_e   : dispatcher phase, REFILL (top up current lane) or SERVE
//   sel_width : lane index width, never below 1 bit
//   def_width : deficit counter width, one bit wider than a quantum
//   sat_add   : deficit + quantum, clamped at 2^dwid-1
package dwrr_pkg;

  typedef enum logic {
    ST_REFILL = 1'b0,
    ST_SERVE  = 1'b1
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int def_width(input int qwid);
    return qwid + 1;
  endfunction

  // Operands are zero-extended to 32 bits by the caller; the 33-bit sum
  // cannot overflow, so the clamp comparison is exact.
  function automatic logic [32:0] sat_add(input logic [31:0] deficit,
                                          input logic [31:0] quantum,
                                          input int          dwid);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, deficit} + {1'b0, quantum};
    lim = (33'd1 << dwid) - 33'd1;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/deficit_counter.sv
// rtl/deficit_counter.sv - per-lane deficit register with saturating refill
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (deficit -> 0)
//   i_refill     : add i_quantum, clamped at 2^DWID-1
//   i_charge     : subtract PSIZE (caller guarantees deficit >= PSIZE)
//   i_quantum    : this lane's quantum, QWID bits
//   o_deficit    : current deficit, DWID bits
module deficit_counter
  import dwrr_pkg::*;
#(
  parameter int QWID  = 8,
  parameter int DWID  = 9,
  parameter int PSIZE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_refill,
  input  logic            i_charge,
  input  logic [QWID-1:0] i_quantum,
  output logic [DWID-1:0] o_deficit
);

  logic [DWID-1:0] r_deficit;

  // Refill and charge are mutually exclusive by construction (REFILL vs SERVE).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deficit <= '0;
    end else if (i_refill) begin
      r_deficit <= DWID'(sat_add(32'(r_deficit), 32'(i_quantum), DWID));
    end else if (i_charge) begin
      r_deficit <= r_deficit - DWID'(PSIZE);
    end
  end

  assign o_deficit = r_deficit;

endmodule

// File: rtl/dwrr_dispatcher.sv
// rtl/dwrr_dispatcher.sv - DWRR scatter of one packet stream onto NUM_REQS FIFOs
//
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_blk            : freeze; no accept, no state change
//   i_in_vld         : input packet valid
//   i_in_data        : input packet, WIDTH bits
//   o_in_rdy         : packet accepted this cycle when high with i_in_vld
//   i_input_quantums : lane i quantum at [(i+1)*QWID-1 : i*QWID]
//   i_full           : per-lane FIFO full flags
//   o_push           : one-hot FIFO push, combinational
//   o_data_out       : shared FIFO data_in, equal to i_in_data
//   o_cur_sel        : lane currently being served
module dwrr_dispatcher
  import dwrr_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int QWID     = 8,
  parameter int PSIZE    = 8,
  parameter int SELW     = sel_width(NUM_REQS),
  parameter int DWID     = def_width(QWID)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_blk,
  input  logic                     i_in_vld,
  input  logic [WIDTH-1:0]         i_in_data,
  output logic                     o_in_rdy,
  input  logic [NUM_REQS*QWID-1:0] i_input_quantums,
  input  logic [NUM_REQS-1:0]      i_full,
  output logic [NUM_REQS-1:0]      o_push,
  output logic [WIDTH-1:0]         o_data_out,
  output logic [SELW-1:0]          o_cur_sel
);

  localparam logic [DWID-1:0] L_PSIZE = DWID'(PSIZE);
  localparam logic [SELW-1:0] L_LAST  = SELW'(NUM_REQS - 1);

  state_e              r_st;
  state_e              w_st_nxt;
  logic [SELW-1:0]     r_ptr;
  logic [SELW-1:0]     w_ptr_nxt;
  logic [SELW-1:0]     w_ptr_inc;
  logic [DWID-1:0]     w_def [NUM_REQS];
  logic [DWID-1:0]     w_cur_def;
  logic                w_cur_full;
  logic                w_eligible;
  logic                w_last;
  logic [NUM_REQS-1:0] w_refill;
  logic [NUM_REQS-1:0] w_charge;

  assign w_cur_def  = w_def[r_ptr];
  assign w_cur_full = i_full[r_ptr];

  // Eligibility never looks at i_in_vld, so in_rdy stays free of it.
  assign w_eligible = (r_st == ST_SERVE) && (w_cur_def >= L_PSIZE) && !w_cur_full;

  // After this charge the lane can no longer afford another packet.
  assign w_last = (w_cur_def - L_PSIZE) < L_PSIZE;

  // Explicit wrap so non-power-of-two lane counts never visit a ghost lane.
  assign w_ptr_inc = (r_ptr == L_LAST) ? '0 : r_ptr + SELW'(1);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_st  <= ST_REFILL;
      r_ptr <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

  // Next-state logic; blk holds everything.
  always_comb begin
    w_st_nxt  = r_st;
    w_ptr_nxt = r_ptr;
    if (!i_blk) begin
      case (r_st)
        ST_REFILL: begin
          w_st_nxt = ST_SERVE;
        end
        ST_SERVE: begin
          // An eligible lane with no input keeps its turn; an ineligible
          // lane costs a one-cycle bubble and keeps its unused deficit.
          if (!w_eligible || (i_in_vld && w_last)) begin
            w_st_nxt  = ST_REFILL;
            w_ptr_nxt = w_ptr_inc;
          end
        end
        default: begin
          w_st_nxt = ST_REFILL;
        end
      endcase
    end
  end

  // Outputs; reset gates them directly so they drop without waiting for a clock.
  always_comb begin
    o_in_rdy = 1'b0;
    o_push   = '0;
    w_refill = '0;
    if (!i_rst && !i_blk) begin
      o_in_rdy = w_eligible;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (r_ptr == SELW'(i)) begin
          o_push[i]   = w_eligible && i_in_vld;
          w_refill[i] = (r_st == ST_REFILL);
        end
      end
    end
  end

  assign w_charge   = o_push;
  assign o_data_out = i_in_data;
  assign o_cur_sel  = r_ptr;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
    deficit_counter #(
      .QWID  (QWID),
      .DWID  (DWID),
      .PSIZE (PSIZE)
    ) u_deficit (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_refill  (w_refill[g]),
      .i_charge  (w_charge[g]),
      .i_quantum (i_input_quantums[g*QWID +: QWID]),
      .o_deficit (w_def[g])
    );
  end

endmodule
